// File: rtl/dkong_sound_latch_pkg.sv
// Shared constants and types for the Donkey Kong main-side sound command latch.
package dkong_snd_pkg;

    // 6H trigger lines are active-low, so every trigger reads idle after reset.
    localparam logic [6:0] DK_6H_RST       = 7'h7F;

    // Clocks a command may stay unacknowledged (1 ms at 24 MHz).
    localparam int         DK_SACK_TIMEOUT = 24000;

    // Width of the pending/timeout counter; 2**DK_TO_W must exceed DK_SACK_TIMEOUT.
    localparam int         DK_TO_W         = 16;

    // Command handshake states.
    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_WAIT = 1'b1
    } hs_state_t;

endpackage

// File: rtl/dkong_sound_latch_if.sv
// Main CPU write bus as seen by the sound command latches: decoded address bits,
// data and one level write enable per latch.
interface dkong_sound_latch_if;

    logic [2:0] I_CPU_A;
    logic [7:0] I_CPU_D;
    logic       I_3D_WE;
    logic       I_6H_WE;
    logic       I_5H_WE;
    logic       I_4H_WE;

    // Address decoder / CPU side drives the bus.
    modport master (
        output I_CPU_A, I_CPU_D, I_3D_WE, I_6H_WE, I_5H_WE, I_4H_WE
    );

    // Latch side only observes it.
    modport slave (
        input  I_CPU_A, I_CPU_D, I_3D_WE, I_6H_WE, I_5H_WE, I_4H_WE
    );

endinterface

// File: rtl/dkong_ls259.sv
// Generic LS259-style addressable latch: on commit, the bit selected by addr
// takes d and every other bit holds. Addresses at or beyond WIDTH are ignored.
module dkong_ls259 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit,
    input  logic [2:0]       addr,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Single-bit update of the addressed latch bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RST_VAL;
        end else if (commit) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (addr == 3'(i)) begin
                    q_r[i] <= d;
                end
            end
        end
    end

    assign q = q_r;

endmodule

// File: rtl/dkong_sound_latch.sv
// Main-CPU side of the sound command interface: turns CPU write strobes into the
// 3D byte latch and 6H/5H/4H addressable latches, and tracks the sound CPU
// acknowledge (SACK) with a pending/timeout handshake.
module dkong_sound_latch
    import dkong_snd_pkg::*;
#(
    parameter logic [6:0] P_6H_RST  = DK_6H_RST,
    parameter int         P_TIMEOUT = DK_SACK_TIMEOUT,
    parameter int         P_TO_W    = DK_TO_W
) (
    input  logic                      W_CLK_24M,
    input  logic                      W_RESETn,
    dkong_sound_latch_if.slave        cpu_bus,
    input  logic                      I_SACK,
    output logic [4:0]                O_3D_Q,
    output logic [6:0]                O_6H_Q,
    output logic                      O_5H_Q0,
    output logic [1:0]                O_4H_Q,
    output logic                      O_SACK_S,
    output logic                      O_PENDING,
    output logic                      O_TIMEOUT,
    output logic                      O_OVERRUN
);

    localparam logic [P_TO_W-1:0] CNT_LAST = P_TO_W'(P_TIMEOUT - 1);
    localparam logic [P_TO_W-1:0] CNT_ONE  = P_TO_W'(1);

    // Strobe bit order: [3]=3D, [2]=6H, [1]=5H, [0]=4H.
    logic [3:0]        we_s;
    logic [3:0]        we_d_r;
    logic [3:0]        commit_r;
    logic [2:0]        a_r;
    logic [4:0]        d_r;
    logic [4:0]        q3d_r;
    logic              unused_d_s;

    logic              sack_s1_r;
    logic              sack_s2_r;
    logic              sack_d_r;
    logic              sack_rise_s;

    hs_state_t         state_r;
    hs_state_t         state_nxt_s;
    logic [P_TO_W-1:0] cnt_r;
    logic [P_TO_W-1:0] cnt_nxt_s;
    logic              timeout_nxt_s;
    logic              overrun_nxt_s;
    logic              pending_r;
    logic              timeout_r;
    logic              overrun_r;

    assign we_s       = {cpu_bus.I_3D_WE, cpu_bus.I_6H_WE, cpu_bus.I_5H_WE, cpu_bus.I_4H_WE};
    assign unused_d_s = ^cpu_bus.I_CPU_D[7:5];

    // Rising-edge detect on each write strobe; address/data are captured with the
    // commit so short strobes still apply the right value one clock later.
    // we_d resets high so a strobe held across reset release never commits.
    always_ff @(posedge W_CLK_24M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            we_d_r   <= 4'b1111;
            commit_r <= 4'b0000;
            a_r      <= 3'b000;
            d_r      <= 5'b00000;
        end else begin
            we_d_r   <= we_s;
            commit_r <= we_s & ~we_d_r;
            a_r      <= cpu_bus.I_CPU_A;
            d_r      <= cpu_bus.I_CPU_D[4:0];
        end
    end

    // 3D command byte latch.
    always_ff @(posedge W_CLK_24M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            q3d_r <= 5'b00000;
        end else if (commit_r[3]) begin
            q3d_r <= d_r;
        end
    end

    dkong_ls259 #(.WIDTH(7), .RST_VAL(P_6H_RST)) u_6h (
        .clk    (W_CLK_24M),
        .rst_n  (W_RESETn),
        .commit (commit_r[2]),
        .addr   (a_r),
        .d      (d_r[0]),
        .q      (O_6H_Q)
    );

    dkong_ls259 #(.WIDTH(1), .RST_VAL(1'b0)) u_5h (
        .clk    (W_CLK_24M),
        .rst_n  (W_RESETn),
        .commit (commit_r[1]),
        .addr   (a_r),
        .d      (d_r[0]),
        .q      (O_5H_Q0)
    );

    dkong_ls259 #(.WIDTH(2), .RST_VAL(2'b00)) u_4h (
        .clk    (W_CLK_24M),
        .rst_n  (W_RESETn),
        .commit (commit_r[0]),
        .addr   (a_r),
        .d      (d_r[0]),
        .q      (O_4H_Q)
    );

    // Two-flop SACK synchroniser plus a delay stage for rising-edge detection.
    always_ff @(posedge W_CLK_24M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            sack_s1_r <= 1'b0;
            sack_s2_r <= 1'b0;
            sack_d_r  <= 1'b0;
        end else begin
            sack_s1_r <= I_SACK;
            sack_s2_r <= sack_s1_r;
            sack_d_r  <= sack_s2_r;
        end
    end

    assign sack_rise_s = sack_s2_r & ~sack_d_r;

    // Handshake next state: a fresh 3D commit always wins over an ack or the
    // terminal count, since any ack seen then belongs to the previous command.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        timeout_nxt_s = 1'b0;
        overrun_nxt_s = 1'b0;
        case (state_r)
            HS_IDLE: begin
                if (commit_r[3]) begin
                    state_nxt_s = HS_WAIT;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = HS_IDLE;
                end
            end
            HS_WAIT: begin
                if (commit_r[3]) begin
                    cnt_nxt_s     = '0;
                    overrun_nxt_s = ~sack_rise_s;
                end else if (sack_rise_s) begin
                    state_nxt_s = HS_IDLE;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s   = HS_IDLE;
                    cnt_nxt_s     = '0;
                    timeout_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = HS_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Handshake state, counter and registered status outputs.
    always_ff @(posedge W_CLK_24M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            state_r   <= HS_IDLE;
            cnt_r     <= '0;
            pending_r <= 1'b0;
            timeout_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            pending_r <= (state_nxt_s == HS_WAIT);
            timeout_r <= timeout_nxt_s;
            overrun_r <= overrun_nxt_s;
        end
    end

    assign O_3D_Q    = q3d_r;
    assign O_SACK_S  = sack_s2_r;
    assign O_PENDING = pending_r;
    assign O_TIMEOUT = timeout_r;
    assign O_OVERRUN = overrun_r;

endmodule

// File: tb/tb_dkong_sound_latch.sv
// Directed bench for dkong_sound_latch with hand-computed expectations.
module tb_dkong_sound_latch;

    logic       W_CLK_24M = 1'b0;
    logic       W_RESETn  = 1'b0;
    logic       I_SACK    = 1'b0;
    logic [4:0] O_3D_Q;
    logic [6:0] O_6H_Q;
    logic       O_5H_Q0;
    logic [1:0] O_4H_Q;
    logic       O_SACK_S;
    logic       O_PENDING;
    logic       O_TIMEOUT;
    logic       O_OVERRUN;

    int checks   = 0;
    int failures = 0;
    int bad_cnt;

    dkong_sound_latch_if bus_if ();

    dkong_sound_latch #(.P_TIMEOUT(16)) dut (
        .W_CLK_24M (W_CLK_24M),
        .W_RESETn  (W_RESETn),
        .cpu_bus   (bus_if.slave),
        .I_SACK    (I_SACK),
        .O_3D_Q    (O_3D_Q),
        .O_6H_Q    (O_6H_Q),
        .O_5H_Q0   (O_5H_Q0),
        .O_4H_Q    (O_4H_Q),
        .O_SACK_S  (O_SACK_S),
        .O_PENDING (O_PENDING),
        .O_TIMEOUT (O_TIMEOUT),
        .O_OVERRUN (O_OVERRUN)
    );

    always #5 W_CLK_24M = ~W_CLK_24M;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: active edge, then settle on the falling edge.
    task automatic tick();
        @(posedge W_CLK_24M);
        @(negedge W_CLK_24M);
    endtask

    // One-clock strobe on a 6H/5H/4H latch; result visible after the second edge.
    task automatic wr_bit(input int which, input logic [2:0] a, input logic [7:0] d);
        bus_if.I_CPU_A = a;
        bus_if.I_CPU_D = d;
        case (which)
            6:       bus_if.I_6H_WE = 1'b1;
            5:       bus_if.I_5H_WE = 1'b1;
            default: bus_if.I_4H_WE = 1'b1;
        endcase
        tick();
        bus_if.I_6H_WE = 1'b0;
        bus_if.I_5H_WE = 1'b0;
        bus_if.I_4H_WE = 1'b0;
        tick();
    endtask

    // One-clock 3D strobe; returns on the edge where the command is applied.
    task automatic wr_3d(input logic [7:0] d);
        bus_if.I_CPU_D = d;
        bus_if.I_3D_WE = 1'b1;
        tick();
        bus_if.I_3D_WE = 1'b0;
        tick();
    endtask

    initial begin
        bus_if.I_CPU_A = 3'd0;
        bus_if.I_CPU_D = 8'h00;
        bus_if.I_3D_WE = 1'b1;
        bus_if.I_6H_WE = 1'b1;
        bus_if.I_5H_WE = 1'b1;
        bus_if.I_4H_WE = 1'b1;
        W_RESETn = 1'b0;
        repeat (3) tick();

        // Reset state with every strobe held high.
        check_eq("rst_6h", 32'(O_6H_Q), 32'h7F);
        check_eq("rst_3d", 32'(O_3D_Q), 32'h0);
        check_eq("rst_misc", 32'({O_5H_Q0, O_4H_Q, O_SACK_S, O_PENDING, O_TIMEOUT, O_OVERRUN}), 32'h0);

        // Release with strobes still high: nothing may commit.
        W_RESETn = 1'b1;
        repeat (3) tick();
        check_eq("rel_6h", 32'(O_6H_Q), 32'h7F);
        check_eq("rel_3d_pend", 32'({O_3D_Q, O_PENDING}), 32'h0);
        bus_if.I_3D_WE = 1'b0;
        bus_if.I_6H_WE = 1'b0;
        bus_if.I_5H_WE = 1'b0;
        bus_if.I_4H_WE = 1'b0;
        repeat (2) tick();

        // 3D write, 4-clock strobe: output 2 clocks after WE rise.
        bus_if.I_CPU_D = 8'hF3;
        bus_if.I_3D_WE = 1'b1;
        tick();
        check_eq("3d_1clk", 32'(O_3D_Q), 32'h0);
        tick();
        check_eq("3d_2clk", 32'(O_3D_Q), 32'h13);
        check_eq("3d_pend", 32'(O_PENDING), 32'h1);
        repeat (2) tick();
        bus_if.I_3D_WE = 1'b0;
        tick();
        check_eq("3d_one_commit", 32'(O_OVERRUN), 32'h0);
        I_SACK = 1'b1;
        repeat (3) tick();
        check_eq("sack_sync", 32'(O_SACK_S), 32'h1);
        check_eq("sack_pend", 32'(O_PENDING), 32'h0);
        I_SACK = 1'b0;
        repeat (3) tick();

        // 6H addressable latch.
        wr_bit(6, 3'd0, 8'h00);
        check_eq("6h_a0", 32'(O_6H_Q), 32'h7E);
        wr_bit(6, 3'd2, 8'h01);
        check_eq("6h_a2", 32'(O_6H_Q), 32'h7E);
        wr_bit(6, 3'd7, 8'h00);
        check_eq("6h_a7", 32'(O_6H_Q), 32'h7E);
        wr_bit(6, 3'd1, 8'h00);
        check_eq("6h_a1", 32'(O_6H_Q), 32'h7C);
        wr_bit(6, 3'd6, 8'hFE);
        check_eq("6h_a6", 32'(O_6H_Q), 32'h3C);

        // Simultaneous 5H and 4H commits.
        bus_if.I_CPU_A = 3'd0;
        bus_if.I_CPU_D = 8'h01;
        bus_if.I_5H_WE = 1'b1;
        bus_if.I_4H_WE = 1'b1;
        tick();
        check_eq("sim_1clk", 32'({O_5H_Q0, O_4H_Q}), 32'h0);
        bus_if.I_5H_WE = 1'b0;
        bus_if.I_4H_WE = 1'b0;
        tick();
        check_eq("sim_5h_4h", 32'({O_5H_Q0, O_4H_Q}), 32'h5);
        wr_bit(4, 3'd3, 8'h01);
        check_eq("4h_a3", 32'(O_4H_Q), 32'h1);
        wr_bit(4, 3'd1, 8'h01);
        check_eq("4h_a1", 32'(O_4H_Q), 32'h3);
        wr_bit(5, 3'd1, 8'h00);
        check_eq("5h_a1", 32'(O_5H_Q0), 32'h1);

        // Timeout: 16 clocks in WAIT without an ack.
        wr_3d(8'h05);
        check_eq("to_enter", 32'({O_3D_Q, O_PENDING}), 32'({5'h05, 1'b1}));
        bad_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (O_TIMEOUT !== 1'b0 || O_PENDING !== 1'b1) bad_cnt++;
        end
        check_eq("to_early", 32'(bad_cnt), 32'h0);
        tick();
        check_eq("to_pulse", 32'({O_TIMEOUT, O_PENDING}), 32'h2);
        tick();
        check_eq("to_once", 32'(O_TIMEOUT), 32'h0);

        // Overrun: second write while pending restarts the counter.
        wr_3d(8'h0A);
        repeat (5) tick();
        wr_3d(8'h15);
        check_eq("ovr_pulse", 32'({O_OVERRUN, O_PENDING, O_3D_Q}), 32'({1'b1, 1'b1, 5'h15}));
        tick();
        check_eq("ovr_once", 32'(O_OVERRUN), 32'h0);
        repeat (14) tick();
        check_eq("ovr_restart", 32'({O_PENDING, O_TIMEOUT}), 32'h2);
        tick();
        check_eq("ovr_to", 32'({O_PENDING, O_TIMEOUT}), 32'h1);

        // Race: 3D commit on the same cycle as the synchronised SACK rise.
        wr_3d(8'h01);
        repeat (2) tick();
        I_SACK = 1'b1;
        tick();
        bus_if.I_CPU_D = 8'h02;
        bus_if.I_3D_WE = 1'b1;
        tick();
        bus_if.I_3D_WE = 1'b0;
        tick();
        check_eq("race_state", 32'({O_SACK_S, O_PENDING, O_OVERRUN, O_TIMEOUT}), 32'hC);
        check_eq("race_data", 32'(O_3D_Q), 32'h02);
        tick();
        check_eq("race_hold", 32'(O_PENDING), 32'h1);

        // Reset mid-operation with a strobe held high clears at once.
        bus_if.I_6H_WE = 1'b1;
        #1;
        W_RESETn = 1'b0;
        #1;
        check_eq("mid_rst", 32'({O_6H_Q, O_PENDING, O_3D_Q, O_5H_Q0, O_4H_Q}), 32'({7'h7F, 1'b0, 5'h0, 1'b0, 2'b00}));
        tick();
        W_RESETn = 1'b1;
        I_SACK = 1'b0;
        bus_if.I_CPU_A = 3'd0;
        bus_if.I_CPU_D = 8'h00;
        repeat (3) tick();
        check_eq("mid_rel_6h", 32'(O_6H_Q), 32'h7F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
